// File: rtl/jtframe_dwnld_pkg.sv
// Shared types and constants for the ROM-download sequencer.
package jtframe_dwnld_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_HOLD,
        ST_DONE,
        ST_ERROR
    } dwnld_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    function automatic int words(input int len, input int dw);
        return (len * 8) / dw;
    endfunction

endpackage

// File: rtl/jtframe_dwnld_crc16.sv
// Byte-serial CRC-16/CCITT stage; crc_nx exposes the combinational result so
// several stages can be chained within one clock.
module jtframe_crc16
    import jtframe_dwnld_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    input  logic [15:0] crc_in,
    output logic [15:0] crc_nx,
    output logic [15:0] crc
);

    logic [15:0] w_c;
    logic [15:0] r_crc;

    always_comb begin
        w_c = crc_in ^ {din, 8'h00};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[15] ? ((w_c << 1) ^ CRC_POLY) : (w_c << 1);
        end
        crc_nx = w_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc <= CRC_INIT;
        end else if (clr) begin
            r_crc <= CRC_INIT;
        end else if (en) begin
            r_crc <= crc_nx;
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/jtframe_dwnld_driver.sv
// ROM-download sequencer: streams a source image into the ioctl port, then
// holds and releases core reset. JTFRAME_DWNLD_CRC_EN adds a running crc output.
module jtframe_dwnld_driver
    import jtframe_dwnld_pkg::*;
#(
    parameter int AW       = 22,
    parameter int DW       = 8,
    parameter int LEN      = 1024,
    parameter int GAP      = 4,
    parameter int RST_HOLD = 16,
    parameter int TIMEOUT  = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic          ioctl_download,
    output logic          ioctl_wr,
    output logic [AW-1:0] ioctl_addr,
    output logic [DW-1:0] ioctl_dout,
    input  logic          ioctl_wait,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          error
`ifdef JTFRAME_DWNLD_CRC_EN
    ,
    output logic [15:0]   crc
`endif
);

    localparam int WORDS = words(LEN, DW);
    localparam int BYTES = DW / 8;
    localparam int WCW   = $clog2(WORDS + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);
    localparam int GCW   = $clog2(GAP + 2);
    localparam int HCW   = $clog2(RST_HOLD + 1);

    dwnld_state_t  r_state, w_state_next;
    logic [WCW-1:0] r_word;
    logic [TCW-1:0] r_wait_cnt, w_wait_inc;
    logic [GCW-1:0] r_gap_cnt;
    logic [HCW-1:0] r_hold_cnt;
    logic           r_download, r_wr, r_core_rst_n;
    logic [AW-1:0]  r_addr;
    logic [DW-1:0]  r_dout;
    logic           w_start_ok, w_issue, w_last, w_timeout, w_hold_end;

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_issue      = 1'b0;
        w_timeout    = 1'b0;
        w_last       = (r_word == WCW'(WORDS - 1));
        w_wait_inc   = r_wait_cnt + 1'b1;
        w_hold_end   = (r_hold_cnt == HCW'(RST_HOLD - 1));
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: w_state_next = ST_WRITE;
            ST_WRITE: begin
                if (!ioctl_wait) begin
                    w_issue = 1'b1;
                    if (w_last)        w_state_next = ST_HOLD;
                    else if (GAP == 0) w_state_next = ST_FETCH;
                    else               w_state_next = ST_GAP;
                end else if (w_wait_inc == TCW'(TIMEOUT)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_ERROR;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GCW'(GAP - 1)) w_state_next = ST_FETCH;
            end
            ST_HOLD: begin
                if (w_hold_end) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word       <= '0;
            r_wait_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_download   <= 1'b0;
            r_wr         <= 1'b0;
            r_core_rst_n <= 1'b0;
            r_addr       <= '0;
            r_dout       <= '0;
        end else begin
            r_wr <= w_issue;
            if (w_start_ok) begin
                r_word       <= '0;
                r_wait_cnt   <= '0;
                r_download   <= 1'b1;
                r_core_rst_n <= 1'b0;
            end
            // Source memory keeps presenting the current word while stalled,
            // so the data is taken on the cycle the write is actually issued.
            if (w_issue) begin
                r_addr     <= AW'(int'(r_word) * BYTES);
                r_dout     <= src_data;
                r_word     <= r_word + 1'b1;
                r_wait_cnt <= '0;
            end else if (r_state == ST_WRITE) begin
                r_wait_cnt <= w_wait_inc;
            end
            if (w_timeout) begin
                r_download   <= 1'b0;
                r_core_rst_n <= 1'b0;
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 1'b1 : '0;
            // Download drops one cycle into HOLD so the final strobe stays framed by it.
            if (r_state == ST_HOLD) begin
                r_download <= 1'b0;
                r_hold_cnt <= r_hold_cnt + 1'b1;
                if (w_hold_end) r_core_rst_n <= 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign src_addr       = AW'(r_word);
    assign ioctl_download = r_download;
    assign ioctl_wr       = r_wr;
    assign ioctl_addr     = r_addr;
    assign ioctl_dout     = r_dout;
    assign core_rst_n     = r_core_rst_n;
    assign done           = (r_state == ST_DONE);
    assign error          = (r_state == ST_ERROR);
    assign busy           = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);

`ifdef JTFRAME_DWNLD_CRC_EN
    logic [BYTES-1:0][15:0] w_seed, w_nx, w_reg;
    logic                   w_unused_crc;

    // Lane 0 (LSB byte) is seeded by the last lane's register; later lanes chain off crc_nx.
    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_crc
            jtframe_crc16 u_crc (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (w_start_ok),
                .en     (w_issue),
                .din    (src_data[gi*8 +: 8]),
                .crc_in (w_seed[gi]),
                .crc_nx (w_nx[gi]),
                .crc    (w_reg[gi])
            );
            if (gi == 0) begin : g_first
                assign w_seed[gi] = w_reg[BYTES-1];
            end else begin : g_chain
                assign w_seed[gi] = w_nx[gi-1];
            end
        end
    endgenerate

    assign crc          = w_reg[BYTES-1];
    assign w_unused_crc = ^{w_nx[BYTES-1], w_reg[0]};
`endif

endmodule

// File: tb/tb_jtframe_dwnld_driver.sv
// Scoreboard bench for jtframe_dwnld_driver with random images and ioctl_wait patterns.
module tb_jtframe_dwnld_driver;

    localparam int AW = 22, DW = 16, LEN = 32, GAP = 1, RST_HOLD = 16, TIMEOUT = 64;
    localparam int NW = LEN * 8 / DW;
    localparam int NB = DW / 8;

    logic clk, rst_n, start, ioctl_wait;
    logic [AW-1:0] src_addr, ioctl_addr;
    logic [DW-1:0] src_data, ioctl_dout;
    logic ioctl_download, ioctl_wr, core_rst_n, busy, done, error;
`ifdef JTFRAME_DWNLD_CRC_EN
    logic [15:0] crc;
    logic [15:0] exp_crc;
`endif

    jtframe_dwnld_driver #(
        .AW(AW), .DW(DW), .LEN(LEN), .GAP(GAP), .RST_HOLD(RST_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .src_data(src_data),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error)
`ifdef JTFRAME_DWNLD_CRC_EN
        , .crc(crc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous source memory: one cycle read latency.
    logic [DW-1:0] mem [NW];
    always @(posedge clk)
        src_data <= (int'(src_addr) < NW) ? mem[src_addr[$clog2(NW)-1:0]] : '0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } wr_t;
    wr_t exp_q[$];
    wr_t e;

    int n_vec = 0, n_miss = 0;
    int cyc = 0, wr_cnt = 0, prev_wr_cyc = 0, last_wr_cyc = 0;
    int wait_mode = 0, stall_left = 0;
    bit have_prev = 0, wait_seen = 0, wait_at_edge = 0, post_last = 0, prev_core_rst = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        wait_at_edge = ioctl_wait;
        if (ioctl_wait) wait_seen = 1;
    end

    // ioctl_wait driver: 0 none, 1 random bursts, 2 stuck high, 3 one 40-cycle stall at word 5
    always @(negedge clk) begin
        case (wait_mode)
            1: ioctl_wait = ($urandom_range(0, 3) == 0);
            2: ioctl_wait = 1'b1;
            3: begin
                if (wr_cnt == 5 && stall_left > 0) begin
                    ioctl_wait = 1'b1;
                    stall_left--;
                end else begin
                    ioctl_wait = 1'b0;
                end
            end
            default: ioctl_wait = 1'b0;
        endcase
    end

    // Monitor: every ioctl_wr pops one expected write.
    always @(negedge clk) begin
        if (post_last) begin
            check("download_low_in_hold", 32'(ioctl_download), 0);
            check("busy_in_hold", 32'(busy), 1);
            post_last = 0;
        end
        if (ioctl_wr) begin
            check("wr_issued_while_wait", 32'(wait_at_edge), 0);
            check("download_during_wr", 32'(ioctl_download), 1);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_wr: got addr %0h data %0h, required no write", ioctl_addr, ioctl_dout);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(ioctl_addr), 32'(e.addr));
                check("wr_data", 32'(ioctl_dout), 32'(e.data));
                if (have_prev && !wait_seen) check("wr_period", 32'(cyc - prev_wr_cyc), GAP + 2);
                if (e.last) begin
                    post_last   = 1;
                    last_wr_cyc = cyc;
                end
            end
            have_prev   = 1;
            prev_wr_cyc = cyc;
            wait_seen   = 0;
            wr_cnt++;
        end
        if (core_rst_n && !prev_core_rst) begin
            check("core_rst_release_delay", 32'(cyc - last_wr_cyc), RST_HOLD);
            check("done_at_core_rst", 32'(done), 1);
        end
        prev_core_rst = core_rst_n;
    end

    // Reference: bitwise CRC-16/CCITT over the image, low byte of each word first.
    function automatic logic [15:0] crc_model();
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'hFFFF;
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < NB; k++) begin
                b = mem[w][k*8 +: 8];
                for (int i = 7; i >= 0; i--) begin
                    fb = c[15] ^ b[i];
                    c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
                end
            end
        return c;
    endfunction

    task automatic load_image(input int mode);
        wr_t x;
        exp_q.delete();
        for (int i = 0; i < NW; i++) begin
            mem[i] = DW'($urandom);
            x.addr = AW'(i * NB);
            x.data = mem[i];
            x.last = (i == NW - 1);
            exp_q.push_back(x);
        end
`ifdef JTFRAME_DWNLD_CRC_EN
        exp_crc = crc_model();
`endif
        have_prev  = 0;
        wr_cnt     = 0;
        stall_left = 40;
        wait_mode  = mode;
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic finish_transfer(input string tag);
        bit ok;
        ok = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_done_timeout: got done=0 after 3000 cycles, required done=1", tag);
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_error"}, 32'(error), 0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_download"}, 32'(ioctl_download), 0);
        check({tag, "_writes_left"}, 32'(exp_q.size()), 0);
`ifdef JTFRAME_DWNLD_CRC_EN
        check({tag, "_crc"}, 32'(crc), 32'(exp_crc));
`endif
        wait_mode = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_src_addr"}, 32'(src_addr), 0);
        check({tag, "_download"}, 32'(ioctl_download), 0);
        check({tag, "_wr"}, 32'(ioctl_wr), 0);
        check({tag, "_ioctl_addr"}, 32'(ioctl_addr), 0);
        check({tag, "_dout"}, 32'(ioctl_dout), 0);
        check({tag, "_core_rst_n"}, 32'(core_rst_n), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        ioctl_wait = 1'b0;
        for (int i = 0; i < NW; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        @(negedge clk);

        load_image(0); pulse_start(); finish_transfer("plain");
        load_image(1); pulse_start(); finish_transfer("rand_wait");
        load_image(3); pulse_start(); finish_transfer("long_stall");

        // Wait stuck high: FETCH takes one cycle, then TIMEOUT stalled cycles.
        exp_q.delete();
        have_prev = 0;
        wait_mode = 2;
        repeat (2) @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= TIMEOUT + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == TIMEOUT + 1) check("error_before_timeout", 32'(error), 0);
            if (k == TIMEOUT + 2) check("error_at_timeout", 32'(error), 1);
        end
        check("timeout_core_rst_n", 32'(core_rst_n), 0);
        check("timeout_download", 32'(ioctl_download), 0);
        check("timeout_busy", 32'(busy), 0);
        check("timeout_done", 32'(done), 0);
`ifdef JTFRAME_DWNLD_CRC_EN
        check("timeout_crc", 32'(crc), 32'h0000FFFF);
`endif
        wait_mode = 0;
        repeat (3) @(negedge clk);
        load_image(0); pulse_start(); finish_transfer("after_error");

        // Asynchronous reset during word 7.
        load_image(0);
        pulse_start();
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (wr_cnt >= 7) break;
        end
        check("reached_word7", 32'(wr_cnt >= 7), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_image(1); pulse_start(); finish_transfer("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
